// File: rtl/sram_acc_pkg.sv
// Shared types for the scalar-to-line SRAM access controller: FSM states,
// request size encodings and the size-to-byte-mask helper.
package sram_acc_pkg;

  localparam int LINE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  // Bytes touched by a scalar access, always starting at lane 0 of the line.
  function automatic logic [LINE_BYTES-1:0] size_mask(input size_e size);
    logic [LINE_BYTES-1:0] m;
    m = '0;
    case (size)
      SZ_BYTE: m[0]   = 1'b1;
      SZ_HALF: m[1:0] = 2'b11;
      SZ_WORD: m[3:0] = 4'hF;
      default: m      = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Request/response port of the SRAM access controller; master is the requester,
// slave is the controller, which also reports its FSM state on dbg_state.
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  // Both channels use plain valid/ready: a transfer happens on the clk edge
  // where valid & ready are high; valid and payload hold until that edge.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [1:0]        dbg_state;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state
  );

endinterface

// File: rtl/sram_acc_lane_fmt.sv
// Combinational lane formatting: size->byte mask, store data placement and load
// extraction/extension. Alignment errors only when SRAM_ACC_ALIGN_CHK_EN is defined.
module sram_acc_lane_fmt
  import sram_acc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LINE_W = 512
) (
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     rd_word,
  output logic [LINE_BYTES-1:0] mask,
  output logic [LINE_W-1:0]     wline,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err
);

  logic misaligned;

`ifdef SRAM_ACC_ALIGN_CHK_EN
  assign misaligned = ((size_e'(size) == SZ_HALF) && addr_lo[0]) ||
                      ((size_e'(size) == SZ_WORD) && (addr_lo != 2'b00));
`else
  // Misaligned accesses simply span the next bytes; the SRAM handles wrap.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo;
  assign misaligned     = 1'b0;
`endif

  assign err   = (size_e'(size) == SZ_RSVD) || misaligned;
  assign mask  = err ? '0 : size_mask(size_e'(size));
  assign wline = {{(LINE_W-DATA_W){1'b0}}, wdata};

  always_comb begin
    rdata = '0;
    case (size_e'(size))
      SZ_BYTE: rdata = {{(DATA_W-8){is_signed & rd_word[7]}}, rd_word[7:0]};
      SZ_HALF: rdata = {{(DATA_W-16){is_signed & rd_word[15]}}, rd_word[15:0]};
      SZ_WORD: rdata = rd_word;
      default: rdata = '0;
    endcase
    if (err) rdata = '0;
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-outstanding scalar load/store controller in front of the line SRAM.
// Optional alignment checking is enabled by defining SRAM_ACC_ALIGN_CHK_EN.
module sram_access_ctrl
  import sram_acc_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LINE_W = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_access_ctrl_if.slave     bus,
  output logic                  sram_w_en,
  output logic [LINE_BYTES-1:0] sram_w_mask,
  output logic [ADDR_W-1:0]     sram_address,
  output logic [LINE_W-1:0]     sram_write_data,
  input  logic [LINE_W-1:0]     sram_read_data
);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
  localparam logic [1:0] ST_RESP   = 2'(RESP);

  logic [1:0]            state_q, state_d;
  logic                  we_q, signed_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, rdata_q;

  logic                  accept, in_access, do_write;
  logic                  fmt_err;
  logic [LINE_BYTES-1:0] fmt_mask;
  logic [LINE_W-1:0]     fmt_wline;
  logic [DATA_W-1:0]     fmt_rdata;

  // Only the low DATA_W bits of the read line carry payload.
  logic unused_rd_hi;
  assign unused_rd_hi = ^sram_read_data[LINE_W-1:DATA_W];

  // rsp_ready feeds req_ready combinationally so RESP can hand off straight to ACCESS.
  assign bus.req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_access     = (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_d = accept ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= bus.req_we;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
      if (in_access) begin
        err_q   <= fmt_err;
        rdata_q <= we_q ? '0 : fmt_rdata;
      end
    end
  end

  sram_acc_lane_fmt #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) u_lane_fmt (
    .size      (size_q),
    .is_signed (signed_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rd_word   (sram_read_data[DATA_W-1:0]),
    .mask      (fmt_mask),
    .wline     (fmt_wline),
    .rdata     (fmt_rdata),
    .err       (fmt_err)
  );

  // SRAM controls are decoded from state so an async reset drops them at once.
  assign do_write        = in_access && we_q && !fmt_err;
  assign sram_w_en       = do_write;
  assign sram_w_mask     = do_write ? fmt_mask : '0;
  assign sram_write_data = do_write ? fmt_wline : '0;
  assign sram_address    = addr_q;

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: table of scalar transactions against a
// byte-array SRAM model, plus backpressure and reset corner sequences.
module tb_sram_access_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LINE_W = 512;

  logic              clk;
  logic              rst_n;
  logic              sram_w_en;
  logic [15:0]       sram_w_mask;
  logic [ADDR_W-1:0] sram_address;
  logic [LINE_W-1:0] sram_write_data;
  logic [LINE_W-1:0] sram_read_data;

  logic [7:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  sram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_access_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .sram_w_en       (sram_w_en),
    .sram_w_mask     (sram_w_mask),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data)
  );

  // Clock and SRAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sram_read_data = '0;
    for (int i = 0; i < 16; i++)
      sram_read_data[8*i +: 8] = mem[16'(sram_address + 16'(i))];
  end

  always @(posedge clk) begin
    if (sram_w_en)
      for (int i = 0; i < 16; i++)
        if (sram_w_mask[i]) mem[16'(sram_address + 16'(i))] = sram_write_data[8*i +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: one transaction with immediate response acceptance.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int wen_cycles, output logic [15:0] mask_seen);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.rsp_ready  = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; wen_cycles = 0; mask_seen = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (sram_w_en) begin
        wen_cycles++;
        mask_seen = sram_w_mask;
      end
      if (bus.rsp_valid) break;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_wen;
    logic [15:0] exp_mask;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat, wen_cycles;
    logic [15:0] mask_seen;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0202] = 8'h55;
    mem[16'h0204] = 8'h55;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 16'h0100, 32'hDEADBEEF, 32'h00000000, 1'b0, 1, 16'h000F};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 16'h0100, 32'h0,        32'hDEADBEEF, 1'b0, 0, 16'h0000};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 16'h0203, 32'h00000080, 32'h00000000, 1'b0, 1, 16'h0001};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 16'h0203, 32'h0,        32'hFFFFFF80, 1'b0, 0, 16'h0000};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 16'h0203, 32'h0,        32'h00000080, 1'b0, 0, 16'h0000};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 16'h0202, 32'h0,        32'hFFFF8055, 1'b0, 0, 16'h0000};
`ifdef SRAM_ACC_ALIGN_CHK_EN
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h11223344, 32'h00000000, 1'b1, 0, 16'h0000};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 32'h0,        32'h00000000, 1'b0, 0, 16'h0000};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 16'hFFFF, 32'h0,        32'h00000000, 1'b0, 0, 16'h0000};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 16'h0101, 32'h0,        32'h00000000, 1'b1, 0, 16'h0000};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 16'h0203, 32'h0,        32'h00000000, 1'b1, 0, 16'h0000};
`else
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h11223344, 32'h00000000, 1'b0, 1, 16'h000F};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 32'h0,        32'h00000022, 1'b0, 0, 16'h0000};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 16'hFFFF, 32'h0,        32'h00000033, 1'b0, 0, 16'h0000};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 16'h0101, 32'h0,        32'h00DEADBE, 1'b0, 0, 16'h0000};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 16'h0203, 32'h0,        32'h00005580, 1'b0, 0, 16'h0000};
`endif
    vecs[9]  = '{1'b0, 2'd3, 1'b0, 16'h0100, 32'h0,        32'h00000000, 1'b1, 0, 16'h0000};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 16'h0300, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 16'h0000};
    vecs[11] = '{1'b0, 2'd2, 1'b1, 16'h0100, 32'h0,        32'hDEADBEEF, 1'b0, 0, 16'h0000};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 16'h0102, 32'h0,        32'h0000DEAD, 1'b0, 0, 16'h0000};
    vecs[13] = '{1'b0, 2'd1, 1'b1, 16'h0100, 32'h0,        32'hFFFFBEEF, 1'b0, 0, 16'h0000};

    // Reset block
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_w_en", 32'(sram_w_en), 32'd0);
    check("rst_w_mask", 32'(sram_w_mask), 32'd0);
    check("rst_wdata_or", 32'(|sram_write_data), 32'd0);
    check("rst_address", 32'(sram_address), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table-driven transactions
    for (int v = 0; v < 16; v++) begin
      run_txn(vecs[v].we, vecs[v].size, vecs[v].sgn, vecs[v].addr, vecs[v].wdata,
              rdata, err, lat, wen_cycles, mask_seen);
      check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd2);
      check($sformatf("v%0d_wen_cycles", v), 32'(wen_cycles), 32'(vecs[v].exp_wen));
      check($sformatf("v%0d_mask", v), 32'(mask_seen), 32'(vecs[v].exp_mask));
    end
    check("nbr_0202", 32'(mem[16'h0202]), 32'h55);
    check("nbr_0204", 32'(mem[16'h0204]), 32'h55);
    check("rsvd_no_write", 32'(mem[16'h0300]), 32'h00);
`ifdef SRAM_ACC_ALIGN_CHK_EN
    check("wrap_fffe_unwritten", 32'(mem[16'hFFFE]), 32'h00);
`else
    check("wrap_fffe", 32'(mem[16'hFFFE]), 32'h44);
    check("wrap_0001", 32'(mem[16'h0001]), 32'h11);
`endif

    // Backpressure: response held 5 cycles, then back-to-back accept
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 16'h0100; bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(lat);
    check("bp_first_latency", 32'(lat), 32'd2);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 16'h0203;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_hold%0d_rdata", k), bus.rsp_rdata, 32'hDEADBEEF);
      check($sformatf("bp_hold%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1 check("bp_req_ready_comb", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 begin bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; end
    wait_rsp(lat);
    check("bp_second_latency", 32'(lat), 32'd2);
    check("bp_second_rdata", bus.rsp_rdata, 32'h00000080);
    check("bp_second_err", 32'(bus.rsp_err), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;

    // Reset asserted during the ACCESS cycle of a store
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 16'h0400; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 check("rstacc_w_en_before", 32'(sram_w_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstacc_w_en_after", 32'(sram_w_en), 32'd0);
    check("rstacc_w_mask", 32'(sram_w_mask), 32'd0);
    check("rstacc_address", 32'(sram_address), 32'd0);
    check("rstacc_req_ready", 32'(bus.req_ready), 32'd1);
    check("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstacc_state", 32'(bus.dbg_state), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("rstacc_mem_unchanged", {mem[16'h0403], mem[16'h0402], mem[16'h0401], mem[16'h0400]}, 32'h0);

    // Reset asserted while a response is pending
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 16'h0100;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(lat);
    check("rstrsp_valid_before", 32'(bus.rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstrsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    check("rstrsp_rdata_after", bus.rsp_rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

endmodule
